pipelined_cla_addsub: RTL

- Parametrised successor to the team's 16-bit block carry-lookahead adder: WIDTH-bit add/subtract built from BLOCK-bit lookahead groups, two-level lookahead across groups.
- Two-stage pipeline with valid/ready handshake on input and output, so it drops into the datapath between FIFOs.
- Adds subtract mode, optional saturation and a full flag set (carry, signed overflow, zero, word-level G/P).

---
 rtl/pipelined_cla_addsub.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_addsub.sv
// Two-stage WIDTH-bit carry-lookahead add/subtract with valid/ready handshake.
// Block G/P is computed ahead of S1; carries are resolved across blocks in S2.

module cla_gp_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  output logic             gb,
  output logic             pb
);
  logic [BLOCK-1:0] gi, pi;

  assign gi = x & y;
  assign pi = x ^ y;
  assign pb = &pi;

  always_comb begin
    gb = 1'b0;
    for (int i = 0; i < BLOCK; i++) gb = gi[i] | (pi[i] & gb);
  end
endmodule

module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             g,
  output logic             p
);
  localparam int NB = WIDTH / BLOCK;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c0;
    logic [NB-1:0]    bg;
    logic [NB-1:0]    bp;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             g;
    logic             p;
  } s2_t;

  logic [2:1]       vld_pipe;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] y_eff;
  logic [NB-1:0]    bg_d, bp_d;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;

  assign s2_adv   = !vld_pipe[2] | out_ready;
  assign s1_adv   = !vld_pipe[1] | s2_adv;
  assign in_ready = s1_adv;

  assign y_eff = sub ? ~b : b;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla_gp_block #(.BLOCK(BLOCK)) u_blk (
      .x  (a[k*BLOCK +: BLOCK]),
      .y  (y_eff[k*BLOCK +: BLOCK]),
      .gb (bg_d[k]),
      .pb (bp_d[k])
    );
  end

  always_comb begin
    s1_d    = '0;
    s1_d.x  = a;
    s1_d.y  = y_eff;
    s1_d.c0 = sub | cin;
    s1_d.bg = bg_d;
    s1_d.bp = bp_d;
  end

  // bc carries between blocks via block G/P; c ripples inside a block only.
  logic [WIDTH-1:0] raw;
  logic             bc, c, cmsb, wg, ovf_d;

  always_comb begin
    raw  = '0;
    cmsb = 1'b0;
    bc   = s1_q.c0;
    wg   = 1'b0;
    c    = 1'b0;
    for (int k = 0; k < NB; k++) begin
      c = bc;
      for (int j = 0; j < BLOCK; j++) begin
        raw[k*BLOCK+j] = s1_q.x[k*BLOCK+j] ^ s1_q.y[k*BLOCK+j] ^ c;
        if (k*BLOCK+j == WIDTH-1) cmsb = c;
        c = (s1_q.x[k*BLOCK+j] & s1_q.y[k*BLOCK+j]) |
            ((s1_q.x[k*BLOCK+j] ^ s1_q.y[k*BLOCK+j]) & c);
      end
      bc = s1_q.bg[k] | (s1_q.bp[k] & bc);
      wg = s1_q.bg[k] | (s1_q.bp[k] & wg);
    end
  end

  always_comb begin
    s2_d      = '0;
    ovf_d     = cmsb ^ bc;
    s2_d.cout = bc;
    s2_d.ovf  = ovf_d;
    s2_d.g    = wg;
    s2_d.p    = &s1_q.bp;
    if (SAT != 0 && ovf_d)
      s2_d.sum = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    else
      s2_d.sum = raw;
    s2_d.zero = (s2_d.sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= in_valid;
      if (s1_adv && in_valid) s1_q <= s1_d;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (s2_adv && vld_pipe[1]) s2_q <= s2_d;
    end
  end

  assign out_valid = vld_pipe[2];
  assign sum       = s2_q.sum;
  assign cout      = s2_q.cout;
  assign ovf       = s2_q.ovf;
  assign zero      = s2_q.zero;
  assign g         = s2_q.g;
  assign p         = s2_q.p;
endmodule
